// File: rtl/ws_pkg.sv
// Shared types and defaults for the GRB one-wire bit shipper.
// Optional colour dimming is enabled with the GRB_BRIGHT_EN macro.
package ws_pkg;

    localparam int PIX_W        = 24;
    localparam int BITS_PER_LED = 24;

    localparam int NUM_LEDS_DEF = 8;
    localparam int ADDR_W_DEF   = 3;
    localparam int T0H_DEF      = 40;
    localparam int T1H_DEF      = 80;
    localparam int TBIT_DEF     = 125;
    localparam int TRST_DEF     = 5000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        BIT,
        LATCH
    } shipState_t;

    // Each colour byte is shifted on its own so no bits bleed across channels.
    function automatic logic [PIX_W-1:0] dimPixel(
        input logic [PIX_W-1:0] p,
        input logic [2:0]       sh
    );
        dimPixel = {p[23:16] >> sh, p[15:8] >> sh, p[7:0] >> sh};
    endfunction

endpackage

// File: rtl/ws_bit_timer.sv
// Bit-period timer: produces the high phase and the end-of-bit strobe.
// Counts 0..TBIT-1 while enabled; start clears it for a fresh bit stream.
module ws_bit_timer
    import ws_pkg::*;
#(
    parameter int T0H  = T0H_DEF,
    parameter int T1H  = T1H_DEF,
    parameter int TBIT = TBIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic en,
    input  logic bitval,
    output logic dout_hi,
    output logic bit_end
);

    localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;

    localparam logic [CW-1:0] HI0  = CW'(T0H);
    localparam logic [CW-1:0] HI1  = CW'(T1H);
    localparam logic [CW-1:0] LAST = CW'(TBIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = en && (cnt == LAST);
    assign dout_hi = en && (cnt < (bitval ? HI1 : HI0));

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/grb_bit_shipper.sv
// WS2812-style serializer: ships NUM_LEDS GRB words MSB first, then latches.
// Define GRB_BRIGHT_EN to add the bright[2:0] per-byte dimming input.
module grb_bit_shipper
    import ws_pkg::*;
#(
    parameter int NUM_LEDS = NUM_LEDS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int T0H      = T0H_DEF,
    parameter int T1H      = T1H_DEF,
    parameter int TBIT     = TBIT_DEF,
    parameter int TRST     = TRST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ship,
    input  logic              clr,
`ifdef GRB_BRIGHT_EN
    input  logic [2:0]        bright,
`endif
    input  logic [PIX_W-1:0]  pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_rd,
    output logic              dout,
    output logic              done,
    output logic              all_done,
    output logic              busy
);

    localparam int LW = (TRST > 0) ? $clog2(TRST + 1) : 1;

    localparam logic [LW-1:0]     LATCH_LAST = LW'(TRST);
    localparam logic [ADDR_W-1:0] LAST_LED   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [4:0]        LAST_BIT   = 5'(BITS_PER_LED - 1);

    shipState_t        state;
    logic              clearMode;
    logic [PIX_W-1:0]  shreg;
    logic [PIX_W-1:0]  nextPix;
    logic [4:0]        bitIdx;
    logic [ADDR_W-1:0] ledIdx;
    logic [LW-1:0]     latchCnt;
    logic              pixRdDly;
    logic [2:0]        brightSel;
    logic              doutHi;
    logic              bitEnd;
    logic              timerStart;
    logic              timerEn;

`ifdef GRB_BRIGHT_EN
    assign brightSel = bright;
`else
    assign brightSel = 3'd0;
`endif

    assign timerStart = (state == CAPT);
    assign timerEn    = (state == BIT);

    ws_bit_timer #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) bitTimer (
        .clk     (clk),
        .reset   (reset),
        .start   (timerStart),
        .en      (timerEn),
        .bitval  (shreg[PIX_W-1]),
        .dout_hi (doutHi),
        .bit_end (bitEnd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            clearMode <= 1'b0;
            shreg     <= '0;
            nextPix   <= '0;
            bitIdx    <= '0;
            ledIdx    <= '0;
            latchCnt  <= '0;
            pixRdDly  <= 1'b0;
            pix_addr  <= '0;
            pix_rd    <= 1'b0;
            dout      <= 1'b0;
            done      <= 1'b0;
            all_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pix_rd   <= 1'b0;
            done     <= 1'b0;
            all_done <= 1'b0;
            pixRdDly <= pix_rd;

            unique case (state)
                IDLE: begin
                    dout <= 1'b0;
                    if (ship) begin
                        state     <= FETCH;
                        clearMode <= 1'b0;
                        pix_rd    <= 1'b1;
                        pix_addr  <= '0;
                        busy      <= 1'b1;
                    end else if (clr) begin
                        state     <= FETCH;
                        clearMode <= 1'b1;
                        pix_addr  <= '0;
                        busy      <= 1'b1;
                    end
                end

                FETCH: begin
                    state <= CAPT;
                end

                CAPT: begin
                    shreg  <= clearMode ? '0
                                        : dimPixel(pix_data, brightSel);
                    bitIdx <= '0;
                    ledIdx <= '0;
                    state  <= BIT;
                    if (!clearMode && NUM_LEDS > 1) begin
                        pix_rd   <= 1'b1;
                        pix_addr <= ADDR_W'(1);
                    end
                end

                BIT: begin
                    dout <= doutHi;
                    // Prefetched word lands one cycle after its strobe.
                    if (pixRdDly && !clearMode) begin
                        nextPix <= dimPixel(pix_data, brightSel);
                    end
                    if (bitEnd) begin
                        shreg <= shreg << 1;
                        if (bitIdx == LAST_BIT) begin
                            bitIdx <= '0;
                            if (ledIdx == LAST_LED) begin
                                state    <= LATCH;
                                latchCnt <= '0;
                                dout     <= 1'b0;
                            end else begin
                                ledIdx <= ledIdx + ADDR_W'(1);
                                shreg  <= clearMode ? '0 : nextPix;
                                if (!clearMode &&
                                    int'(ledIdx) + 2 < NUM_LEDS) begin
                                    pix_rd   <= 1'b1;
                                    pix_addr <= ledIdx + ADDR_W'(2);
                                end
                            end
                        end else begin
                            bitIdx <= bitIdx + 5'd1;
                        end
                    end
                end

                LATCH: begin
                    dout <= 1'b0;
                    // done lines up with the end of the last low phase on dout.
                    if (latchCnt == '0) begin
                        done <= 1'b1;
                    end
                    if (latchCnt == LATCH_LAST) begin
                        all_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                        latchCnt <= '0;
                    end else begin
                        latchCnt <= latchCnt + LW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grb_bit_shipper.sv
// Scoreboard bench for grb_bit_shipper: model queues per-bit high times,
// read addresses and frame counts; a negedge monitor decodes dout and checks.
module tb_grb_bit_shipper;

    localparam int NL   = 2;
    localparam int AW   = 1;
    localparam int T0H  = 2;
    localparam int T1H  = 4;
    localparam int TBIT = 6;
    localparam int TRST = 10;
    localparam int NBITS = NL * 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ship = 1'b0;
    logic          clr = 1'b0;
    logic [23:0]   pixData = '0;
    logic [AW-1:0] pixAddr;
    logic          pixRd;
    logic          dout;
    logic          done;
    logic          allDone;
    logic          busy;

    logic [23:0]   mem [NL];

    int expHigh[$];
    int expAddr[$];
    int framesPending = 0;
    int nChk = 0;
    int nErr = 0;
    int cyc = 0;

    int prevDout = 0;
    int prevBusy = 0;
    int inFrame = 0;
    int frameStart = 0;
    int lastRise = 0;
    int bitsInFrame = 0;
    int sawDone = 0;
    int doneCyc = 0;
    int idleRun = 0;
    int holdMode = 0;

    grb_bit_shipper #(
        .NUM_LEDS (NL),
        .ADDR_W   (AW),
        .T0H      (T0H),
        .T1H      (T1H),
        .TBIT     (TBIT),
        .TRST     (TRST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ship     (ship),
        .clr      (clr),
`ifdef GRB_BRIGHT_EN
        .bright   (3'd0),
`endif
        .pix_data (pixData),
        .pix_addr (pixAddr),
        .pix_rd   (pixRd),
        .dout     (dout),
        .done     (done),
        .all_done (allDone),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pixRd) pixData <= mem[pixAddr];
    end

    task automatic check(input string name, input int act, input int exp);
        nChk++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: each bit's high time follows its value, MSB first.
    task automatic pushFrame(input bit pixelMode);
        for (int led = 0; led < NL; led++) begin
            for (int b = 23; b >= 0; b--) begin
                if (pixelMode)
                    expHigh.push_back(mem[led][b] ? T1H : T0H);
                else
                    expHigh.push_back(T0H);
            end
            if (pixelMode) expAddr.push_back(led);
        end
        framesPending++;
    endtask

    task automatic pulse(input logic s, input logic c);
        ship = s;
        clr = c;
        tick(1);
        ship = 1'b0;
        clr = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((framesPending != 0 || busy) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) check("wait_idle_timeout", n, -1);
    endtask

    task automatic randomMem();
        for (int i = 0; i < NL; i++) mem[i] = 24'($urandom);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prevDout = 0;
            prevBusy = 0;
            inFrame = 0;
            sawDone = 0;
            idleRun = 0;
        end else begin
            if (pixRd) begin
                if (expAddr.size() == 0)
                    check("pix_rd_unexpected", int'(pixAddr), -1);
                else
                    check("pix_addr", int'(pixAddr), expAddr.pop_front());
            end
            if (dout && prevDout == 0) begin
                if (inFrame == 0) begin
                    inFrame = 1;
                    frameStart = cyc;
                    bitsInFrame = 0;
                end else begin
                    check("bit_period", cyc - lastRise, TBIT);
                end
                lastRise = cyc;
                bitsInFrame++;
            end
            if (!dout && prevDout == 1) begin
                if (expHigh.size() == 0)
                    check("dout_unexpected_pulse", cyc - lastRise, -1);
                else
                    check("bit_high_time", cyc - lastRise, expHigh.pop_front());
            end
            if (done) begin
                check("done_in_frame", inFrame, 1);
                check("frame_length", cyc - frameStart, NBITS * TBIT);
                check("frame_bits", bitsInFrame, NBITS);
                check("dout_low_at_done", int'(dout), 0);
                doneCyc = cyc;
                inFrame = 0;
                sawDone = 1;
            end
            if (allDone) begin
                check("all_done_after_done", sawDone, 1);
                check("latch_length", cyc - doneCyc, TRST);
                check("busy_low_at_all_done", int'(busy), 0);
                if (framesPending == 0)
                    check("all_done_unexpected", framesPending, 1);
                else
                    framesPending--;
                sawDone = 0;
            end
            if (busy && prevBusy == 0 && holdMode != 0)
                check("idle_gap", idleRun, 1);
            idleRun = busy ? 0 : idleRun + 1;
            prevDout = int'(dout);
            prevBusy = int'(busy);
        end
    end

    initial begin
        mem[0] = 24'hFF0000;
        mem[1] = 24'h000001;

        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("reset_dout", int'(dout), 0);
            check("reset_busy", int'(busy), 0);
            check("reset_done", int'(done), 0);
            check("reset_all_done", int'(allDone), 0);
            check("reset_pix_rd", int'(pixRd), 0);
            tick(1);
        end

        pushFrame(1'b1);
        pulse(1'b1, 1'b0);
        check("busy_after_ship", int'(busy), 1);
        waitIdle(2000);

        pushFrame(1'b0);
        pulse(1'b0, 1'b1);
        waitIdle(2000);

        randomMem();
        pushFrame(1'b1);
        pulse(1'b1, 1'b1);
        waitIdle(2000);

        randomMem();
        pushFrame(1'b1);
        pulse(1'b1, 1'b0);
        begin
            int n = 0;
            while (bitsInFrame < 11 && n < 1000) begin
                tick(1);
                n++;
            end
            if (n >= 1000) check("wait_bit10_timeout", n, -1);
        end
        reset = 1'b1;
        expHigh.delete();
        expAddr.delete();
        framesPending = 0;
        tick(1);
        check("abort_dout", int'(dout), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        reset = 1'b0;
        tick(400);
        pushFrame(1'b1);
        pulse(1'b1, 1'b0);
        waitIdle(2000);

        randomMem();
        pushFrame(1'b1);
        pulse(1'b1, 1'b0);
        tick(100);
        pulse(1'b1, 1'b0);
        tick(50);
        pulse(1'b0, 1'b1);
        waitIdle(2000);
        tick(30);
        check("stay_idle", int'(busy), 0);

        randomMem();
        pushFrame(1'b1);
        pushFrame(1'b1);
        pushFrame(1'b1);
        ship = 1'b1;
        tick(2);
        holdMode = 1;
        begin
            int n = 0;
            while (!(framesPending == 1 && busy) && n < 3000) begin
                tick(1);
                n++;
            end
            if (n >= 3000) check("wait_third_frame_timeout", n, -1);
        end
        ship = 1'b0;
        waitIdle(2000);
        holdMode = 0;

        for (int f = 0; f < 3; f++) begin
            bit pm;
            randomMem();
            pm = 1'($urandom_range(0, 1));
            pushFrame(pm);
            pulse(pm, ~pm);
            waitIdle(2000);
            tick(int'($urandom_range(1, 5)));
        end

        tick(20);
        check("leftover_bits", expHigh.size(), 0);
        check("leftover_addrs", expAddr.size(), 0);
        check("leftover_frames", framesPending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nErr);
        $finish;
    end

endmodule

// File: doc/grb_bit_shipper.md
Name: grb_bit_shipper

Overview:
Downstream serializer driven by the frame sequencer's ship/clear commands. Reads NUM_LEDS 24-bit GRB pixel words from an external pixel buffer and emits the WS2812-style one-wire waveform on dout, MSB first. Returns a done pulse when the last bit finishes and an all_done pulse after the latch (reset-low) period. These pulses feed the sequencer's Done/allDone inputs.

Parameters:
NUM_LEDS, 8, LEDs per frame (>=1)
ADDR_W, 3, pixel address width; 2**ADDR_W >= NUM_LEDS
T0H, 40, clk cycles dout high for a 0 bit
T1H, 80, clk cycles dout high for a 1 bit
TBIT, 125, clk cycles per bit period; T0H < T1H < TBIT, TBIT >= 4
TRST, 5000, clk cycles of latch-low after the frame (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ship  in  1  level request: send the pixel frame
clr  in  1  level request: send an all-zero frame without reading memory
pix_data  in  24  pixel word {G[23:16],R[15:8],B[7:0]}, valid the cycle after pix_rd
pix_addr  out  ADDR_W  pixel read address
pix_rd  out  1  one-cycle read strobe
dout  out  1  serial LED data line
done  out  1  one-cycle pulse: last bit period complete
all_done  out  1  one-cycle pulse: latch period complete
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; dout, done, all_done, busy, pix_rd = 0; pix_addr = 0; all counters 0. Reset mid-frame aborts immediately with no done/all_done pulse.
- States: IDLE, FETCH, CAPT, BIT, LATCH.
- IDLE: ship sampled high -> FETCH with mode=pixel. Else clr sampled high -> FETCH with mode=clear. Ship wins if both are high. Requests are ignored outside IDLE.
- FETCH (1 cycle): pixel mode drives pix_rd=1, pix_addr=0. Clear mode keeps pix_rd=0.
- CAPT (1 cycle): load shift register from pix_data in pixel mode, or 24'h0 in clear mode. Go to BIT; dout rises on the following edge.
- BIT: dout=1 for T1H or T0H cycles according to shreg[23], then 0 for the remainder of TBIT. Shift left at each bit end.
- Prefetch: in pixel mode, pix_rd pulses in the first cycle of bit 0 of LED k with pix_addr=k+1 (only if k+1 < NUM_LEDS). pix_data is captured into next_pix on the next cycle. At the end of bit 23, shreg loads next_pix. Inter-LED gap is zero; the bit stream is continuous.
- After bit 23 of LED NUM_LEDS-1 ends: done=1 for one cycle, go to LATCH, dout=0.
- LATCH: dout=0 for TRST cycles, then all_done=1 for one cycle and return to IDLE (busy=0 the same cycle).
- Frame length from first dout rise to done: NUM_LEDS*24*TBIT cycles.
- Counters: bit timer $clog2(TBIT) bits; bit index 5 bits (0..23); LED index ADDR_W bits, no wrap; latch counter $clog2(TRST+1) bits.
- A ship held high through all_done starts a new frame in the IDLE cycle that follows.

Optional Feature:
Macro GRB_BRIGHT_EN.
- Defined: adds input bright[2:0]. Each colour byte is logically right-shifted by bright when loaded into shreg or next_pix. bright is sampled at each load. Clear mode is unaffected.
- Undefined: no bright port; pixel bytes pass unmodified.

Decomposition:
- Package ws_pkg: state enum, PIX_W=24, BITS_PER_LED=24, default timing constants.
- Sub-module ws_bit_timer: inputs start and bitval; outputs dout_hi and bit_end. Owns the TBIT counter.

Test Plan:
(Params NUM_LEDS=2, T0H=2, T1H=4, TBIT=6, TRST=10.)
1. Reset held 3 cycles, then idle 5 cycles -> dout, busy, done, all_done, pix_rd all 0.
2. Memory {0:24'hFF0000, 1:24'h000001}; ship pulse -> pix_rd at addr 0 then addr 1. Bits 0-7 high 4 cycles; bits 8-46 high 2; bit 47 high 4. done exactly 288 cycles after first rise; all_done 10 cycles after done.
3. clr pulse -> 48 bits each high 2 / low 4; pix_rd never asserted; done then all_done as in 2.
4. ship and clr high the same cycle -> pixel frame as in 2; clr ignored.
5. Reset asserted during bit 10 -> dout=0, busy=0 next cycle, no done; a new ship restarts from addr 0.
6. ship re-pulsed mid-frame -> ignored. ship held high continuously -> back-to-back frames, each separated by exactly 10 latch cycles plus a 1-cycle IDLE.
